// File: rtl/nn_pkg.sv
// Shared fixed-point constants, widths and state type for the NN datapath blocks.
package nn_pkg;
    localparam int NUM_FILTERS = 4;
    localparam int VECTOR_LEN  = 8;
    localparam int DATA_WIDTH  = 16;
    localparam int FRAC_BITS   = 8;

    localparam int TAP_BITS    = $clog2(VECTOR_LEN);
    localparam int FILTER_BITS = $clog2(NUM_FILTERS);
    localparam int ADDR_WIDTH  = FILTER_BITS + TAP_BITS;
    localparam int PROD_WIDTH  = 2 * DATA_WIDTH;
    // Room for VECTOR_LEN full-scale products without overflow.
    localparam int ACC_WIDTH   = PROD_WIDTH + TAP_BITS;

    localparam int SAT_MAX_INT = (2 ** (DATA_WIDTH - 1)) - 1;
    localparam int SAT_MIN_INT = -(2 ** (DATA_WIDTH - 1));
    localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = DATA_WIDTH'(SAT_MAX_INT);
    localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = DATA_WIDTH'(SAT_MIN_INT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQUEST,
        ST_COLLECT,
        ST_DRAIN,
        ST_DONE
    } mac_state_t;
endpackage

// File: rtl/fixed_point_saturate.sv
// Accumulator to Q8.8: arithmetic shift by FRAC_BITS, then clamp to 16-bit signed.
// Define FILTER_MAC_RELU_EN to force negative accumulators to zero before clamping.
module fixed_point_saturate
    import nn_pkg::*;
(
    input  logic signed [ACC_WIDTH-1:0]  acc,
    output logic signed [DATA_WIDTH-1:0] result
);
    localparam int SHIFT_WIDTH = ACC_WIDTH - FRAC_BITS;
    localparam logic signed [SHIFT_WIDTH-1:0] LIM_MAX = SHIFT_WIDTH'(SAT_MAX_INT);
    localparam logic signed [SHIFT_WIDTH-1:0] LIM_MIN = SHIFT_WIDTH'(SAT_MIN_INT);

    logic signed [SHIFT_WIDTH-1:0] shifted;

    // Dropping the low bits of a two's-complement value truncates toward -inf.
    assign shifted = acc[ACC_WIDTH-1:FRAC_BITS];

    always_comb begin
        result = shifted[DATA_WIDTH-1:0];
`ifdef FILTER_MAC_RELU_EN
        if (acc[ACC_WIDTH-1])
            result = '0;
        else if (shifted > LIM_MAX)
            result = SAT_MAX;
`else
        if (shifted > LIM_MAX)
            result = SAT_MAX;
        else if (shifted < LIM_MIN)
            result = SAT_MIN;
`endif
    end
endmodule

// File: rtl/filter_mac_unit.sv
// Dot product of one incoming vector with a selected filter from weight memory.
// Build option FILTER_MAC_RELU_EN (handled in fixed_point_saturate) clips negatives.
//
// state   | meaning
// IDLE    | waiting for start
// REQUEST | one-cycle element request to the vector manager
// COLLECT | accepting elements, issuing weight reads
// DRAIN   | letting the last products reach the accumulator
// DONE    | result offered until result_ready
module filter_mac_unit
    import nn_pkg::*;
(
    input  logic                          clock,
    input  logic                          clear,
    input  logic                          start,
    input  logic [FILTER_BITS-1:0]        filter_select,
    output logic                          busy,
    output logic                          m_element_requested,
    input  logic                          m_element_ready,
    input  logic signed [DATA_WIDTH-1:0]  m_element,
    output logic [ADDR_WIDTH-1:0]         weight_memory_address,
    output logic                          weight_memory_enable,
    input  logic signed [DATA_WIDTH-1:0]  weight_element,
    output logic signed [DATA_WIDTH-1:0]  result,
    output logic                          result_valid,
    input  logic                          result_ready
);
    mac_state_t                   state;
    logic [FILTER_BITS-1:0]       filter_q;
    logic [TAP_BITS-1:0]          tap;
    logic [1:0]                   drain_cnt;
    logic signed [DATA_WIDTH-1:0] elem_s0;
    logic signed [DATA_WIDTH-1:0] elem_s1;
    logic                         valid_s1;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [PROD_WIDTH-1:0] product;
    logic signed [DATA_WIDTH-1:0] sat_result;
    logic                         accept_start;

    assign accept_start = start && ((state == ST_IDLE) || (state == ST_DONE && result_ready));
    assign product      = PROD_WIDTH'(elem_s1) * PROD_WIDTH'(weight_element);

    fixed_point_saturate u_saturate (
        .acc    (acc),
        .result (sat_result)
    );

    // weight_memory_enable doubles as the stage-0 valid bit.
    always_ff @(posedge clock) begin
        if (clear) begin
            elem_s1  <= '0;
            valid_s1 <= 1'b0;
        end else begin
            elem_s1  <= elem_s0;
            valid_s1 <= weight_memory_enable;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state                 <= ST_IDLE;
            busy                  <= 1'b0;
            m_element_requested   <= 1'b0;
            weight_memory_address <= '0;
            weight_memory_enable  <= 1'b0;
            result                <= '0;
            result_valid          <= 1'b0;
            filter_q              <= '0;
            tap                   <= '0;
            drain_cnt             <= '0;
            elem_s0               <= '0;
            acc                   <= '0;
        end else begin
            m_element_requested  <= 1'b0;
            weight_memory_enable <= 1'b0;
            if (valid_s1)
                acc <= acc + ACC_WIDTH'(product);

            case (state)
                ST_IDLE: ;
                ST_REQUEST: state <= ST_COLLECT;
                ST_COLLECT: begin
                    if (m_element_ready) begin
                        elem_s0               <= m_element;
                        weight_memory_address <= {filter_q, tap};
                        weight_memory_enable  <= 1'b1;
                        tap                   <= tap + 1'b1;
                        if (tap == TAP_BITS'(VECTOR_LEN - 1)) begin
                            drain_cnt <= '0;
                            state     <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == 2'd2) begin
                        result       <= sat_result;
                        result_valid <= 1'b1;
                        state        <= ST_DONE;
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end
                ST_DONE: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        busy         <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (accept_start) begin
                filter_q            <= filter_select;
                tap                 <= '0;
                acc                 <= '0;
                m_element_requested <= 1'b1;
                busy                <= 1'b1;
                state               <= ST_REQUEST;
            end
        end
    end
endmodule

// File: tb/tb_filter_mac_unit.sv
// Directed bench for filter_mac_unit with a behavioural synchronous weight memory.
module tb_filter_mac_unit;
    logic        clock = 1'b0;
    logic        clear;
    logic        start;
    logic [1:0]  filter_select;
    logic        busy;
    logic        m_element_requested;
    logic        m_element_ready;
    logic [15:0] m_element;
    logic [4:0]  weight_memory_address;
    logic        weight_memory_enable;
    logic [15:0] weight_element;
    logic [15:0] result;
    logic        result_valid;
    logic        result_ready;

    int errors = 0;
    int checks = 0;
    int lat;
    logic [15:0] wmem  [0:31];
    logic [15:0] elems [0:7];
    logic [4:0]  addr_log [$];

`ifdef FILTER_MAC_RELU_EN
    localparam logic [15:0] EXP_NEG_SAT = 16'h0000;
    localparam logic [15:0] EXP_NEG_ONE = 16'h0000;
    localparam logic [15:0] EXP_NEG_LSB = 16'h0000;
`else
    localparam logic [15:0] EXP_NEG_SAT = 16'h8000;
    localparam logic [15:0] EXP_NEG_ONE = 16'hF800;
    localparam logic [15:0] EXP_NEG_LSB = 16'hFFFF;
`endif

    filter_mac_unit dut (
        .clock                 (clock),
        .clear                 (clear),
        .start                 (start),
        .filter_select         (filter_select),
        .busy                  (busy),
        .m_element_requested   (m_element_requested),
        .m_element_ready       (m_element_ready),
        .m_element             (m_element),
        .weight_memory_address (weight_memory_address),
        .weight_memory_enable  (weight_memory_enable),
        .weight_element        (weight_element),
        .result                (result),
        .result_valid          (result_valid),
        .result_ready          (result_ready)
    );

    always #5 clock = ~clock;

    always @(posedge clock)
        if (weight_memory_enable)
            weight_element <= wmem[weight_memory_address];

    task automatic send_elems(input logic [15:0] mask, input int count);
        int k = 0;
        addr_log.delete();
        for (int c = 0; c < 16 && k < count; c++) begin
            m_element_ready = mask[c];
            m_element = mask[c] ? elems[k] : 16'hDEAD;
            if (mask[c]) k++;
            @(negedge clock);
            if (weight_memory_enable) addr_log.push_back(weight_memory_address);
        end
        m_element_ready = 1'b0;
    endtask

    task automatic wait_valid(output int l);
        l = 0;
        while (result_valid !== 1'b1 && l < 20) begin
            @(negedge clock);
            l++;
        end
    endtask

    task automatic run_vec(input logic [1:0] f);
        @(negedge clock); start = 1'b1; filter_select = f;
        @(negedge clock); start = 1'b0;
        @(negedge clock);
        send_elems(16'hFFFF, 8);
        wait_valid(lat);
    endtask

    task automatic accept_result();
        result_ready = 1'b1;
        @(negedge clock);
        result_ready = 1'b0;
    endtask

    task automatic test_reset();
        clear = 1'b1; start = 1'b0; filter_select = 2'd0;
        m_element_ready = 1'b0; m_element = 16'h0; result_ready = 1'b0;
        for (int i = 0; i < 32; i++) wmem[i] = 16'h0300 + 16'(i);
        repeat (2) @(negedge clock);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (m_element_requested !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", m_element_requested); end
        checks++; if (weight_memory_address !== 5'd0) begin errors++; $display("FAIL reset_addr: got %h want 00", weight_memory_address); end
        checks++; if (weight_memory_enable !== 1'b0) begin errors++; $display("FAIL reset_en: got %b want 0", weight_memory_enable); end
        checks++; if (result !== 16'h0000) begin errors++; $display("FAIL reset_result: got %h want 0000", result); end
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", result_valid); end
        clear = 1'b0;
    endtask

    task automatic test_basic();
        for (int i = 0; i < 8; i++) begin wmem[i] = 16'h0080; elems[i] = 16'h0100; end
        @(negedge clock); start = 1'b1; filter_select = 2'd0;
        @(negedge clock); start = 1'b0;
        checks++; if (m_element_requested !== 1'b1) begin errors++; $display("FAIL basic_req: got %b want 1", m_element_requested); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
        @(negedge clock);
        checks++; if (m_element_requested !== 1'b0) begin errors++; $display("FAIL basic_req_pulse: got %b want 0", m_element_requested); end
        send_elems(16'hFFFF, 8);
        checks++; if (addr_log.size() != 8) begin errors++; $display("FAIL basic_addr_count: got %0d want 8", addr_log.size()); end
        for (int i = 0; i < addr_log.size(); i++) begin
            checks++; if (addr_log[i] !== 5'(i)) begin errors++; $display("FAIL basic_addr%0d: got %0d want %0d", i, addr_log[i], i); end
        end
        wait_valid(lat);
        checks++; if (lat != 3) begin errors++; $display("FAIL basic_latency: got %0d want 3", lat); end
        checks++; if (result !== 16'h0400) begin errors++; $display("FAIL basic_result: got %h want 0400", result); end
        accept_result();
        checks++; if (busy !== 1'b0 || result_valid !== 1'b0) begin errors++; $display("FAIL basic_idle: got busy=%b valid=%b want 0 0", busy, result_valid); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 8; i++) begin wmem[8+i] = 16'h7FFF; elems[i] = 16'h7FFF; end
        run_vec(2'd1);
        checks++; if (result !== 16'h7FFF) begin errors++; $display("FAIL sat_pos: got %h want 7fff", result); end
        accept_result();
        for (int i = 0; i < 8; i++) elems[i] = 16'h8000;
        run_vec(2'd1);
        checks++; if (result !== EXP_NEG_SAT) begin errors++; $display("FAIL sat_neg: got %h want %h", result, EXP_NEG_SAT); end
        accept_result();
        for (int i = 0; i < 8; i++) begin wmem[8+i] = 16'hFF00; elems[i] = 16'h0100; end
        run_vec(2'd1);
        checks++; if (result !== EXP_NEG_ONE) begin errors++; $display("FAIL neg_one: got %h want %h", result, EXP_NEG_ONE); end
        accept_result();
        for (int i = 0; i < 8; i++) begin wmem[8+i] = 16'hFFFF; elems[i] = 16'h0001; end
        run_vec(2'd1);
        checks++; if (result !== EXP_NEG_LSB) begin errors++; $display("FAIL neg_trunc: got %h want %h", result, EXP_NEG_LSB); end
    endtask

    // Entered with the last saturation vector still sitting in DONE (filter 1).
    task automatic test_hold();
        for (int c = 0; c < 5; c++) begin
            start = (c == 1);
            filter_select = 2'd3;
            m_element_ready = (c == 2);
            m_element = 16'h1111;
            @(negedge clock);
            checks++; if (result !== EXP_NEG_LSB || result_valid !== 1'b1) begin errors++; $display("FAIL hold_result%0d: got %h/%b want %h/1", c, result, result_valid, EXP_NEG_LSB); end
            checks++; if (m_element_requested !== 1'b0 || weight_memory_enable !== 1'b0) begin errors++; $display("FAIL hold_quiet%0d: got req=%b en=%b want 0 0", c, m_element_requested, weight_memory_enable); end
            checks++; if (weight_memory_address !== 5'd15) begin errors++; $display("FAIL hold_addr%0d: got %0d want 15", c, weight_memory_address); end
        end
        start = 1'b0; m_element_ready = 1'b0;
        accept_result();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_clear_mid();
        for (int i = 0; i < 8; i++) begin wmem[16+i] = 16'((i + 1) << 8); elems[i] = 16'h7FFF; end
        @(negedge clock); start = 1'b1; filter_select = 2'd1;
        @(negedge clock); start = 1'b0;
        @(negedge clock);
        send_elems(16'hFFFF, 4);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        checks++; if (busy !== 1'b0 || m_element_requested !== 1'b0) begin errors++; $display("FAIL clr_ctrl: got busy=%b req=%b want 0 0", busy, m_element_requested); end
        checks++; if (weight_memory_address !== 5'd0 || weight_memory_enable !== 1'b0) begin errors++; $display("FAIL clr_mem: got addr=%0d en=%b want 0 0", weight_memory_address, weight_memory_enable); end
        checks++; if (result !== 16'h0000 || result_valid !== 1'b0) begin errors++; $display("FAIL clr_result: got %h/%b want 0000/0", result, result_valid); end
        for (int i = 0; i < 8; i++) elems[i] = 16'h0080;
        run_vec(2'd2);
        checks++; if (result !== 16'h1200) begin errors++; $display("FAIL clr_rerun: got %h want 1200", result); end
        accept_result();
    endtask

    task automatic test_gaps();
        for (int i = 0; i < 8; i++) begin wmem[24+i] = 16'((i + 1) * 16'h0040); elems[i] = 16'h0300; end
        @(negedge clock); start = 1'b1; filter_select = 2'd3;
        @(negedge clock); start = 1'b0;
        @(negedge clock);
        send_elems(16'h172D, 8);
        checks++; if (addr_log.size() != 8) begin errors++; $display("FAIL gap_addr_count: got %0d want 8", addr_log.size()); end
        for (int i = 0; i < addr_log.size(); i++) begin
            checks++; if (addr_log[i] !== 5'(24 + i)) begin errors++; $display("FAIL gap_addr%0d: got %0d want %0d", i, addr_log[i], 24 + i); end
        end
        wait_valid(lat);
        checks++; if (lat != 3) begin errors++; $display("FAIL gap_latency: got %0d want 3", lat); end
        checks++; if (result !== 16'h1B00) begin errors++; $display("FAIL gap_result: got %h want 1b00", result); end
        accept_result();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin wmem[i] = 16'h0080; wmem[8+i] = 16'h0100; elems[i] = 16'((i + 1) << 8); end
        run_vec(2'd0);
        checks++; if (result !== 16'h1200) begin errors++; $display("FAIL b2b_first: got %h want 1200", result); end
        result_ready = 1'b1; start = 1'b1; filter_select = 2'd1;
        @(negedge clock);
        result_ready = 1'b0; start = 1'b0;
        checks++; if (result_valid !== 1'b0 || m_element_requested !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL b2b_restart: got valid=%b req=%b busy=%b want 0 1 1", result_valid, m_element_requested, busy); end
        @(negedge clock);
        send_elems(16'hFFFF, 8);
        wait_valid(lat);
        checks++; if (result !== 16'h2400) begin errors++; $display("FAIL b2b_second: got %h want 2400", result); end
        accept_result();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_hold();
        test_clear_mid();
        test_gaps();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/filter_mac_unit.md
# filter_mac_unit

Consumes the 8-element vector stream emitted by the m-vector manager, multiplies each element by the matching tap of a selected filter held in a weight memory, and accumulates the dot product. Sits directly downstream of the vector manager and upstream of the layer result writer. Output is one saturated Q8.8 word per vector, offered on a valid/ready handshake.

## Interface
- NUM_FILTERS, 4, filters stored in weight memory (power of two)
- VECTOR_LEN, 8, elements per vector (power of two)
- DATA_WIDTH, 16, element/weight/result width, signed
- FRAC_BITS, 8, fractional bits (Q8.8)

- clock  in  1  single clock, all logic on posedge
- clear  in  1  reset, synchronous, active-high
- start  in  1  begin one dot product; sampled only in IDLE or DONE-with-handshake
- filter_select  in  2  filter index, latched on accepted start
- busy  out  1  high in every state except IDLE
- m_element_requested  out  1  one-cycle pulse to vector manager
- m_element_ready  in  1  m_element valid this cycle
- m_element  in  16  signed Q8.8 vector element
- weight_memory_address  out  5  {filter, tap}
- weight_memory_enable  out  1  read strobe, 1-cycle synchronous read
- weight_element  in  16  signed Q8.8 weight, valid the cycle after enable
- result  out  16  saturated signed Q8.8 dot product
- result_valid  out  1  result offered
- result_ready  in  1  downstream accepts

## Operation
- FSM states: IDLE, REQUEST, COLLECT, DRAIN, DONE.
- IDLE: start=1 -> latch filter_select, clear accumulator and tap counter, go REQUEST.
- REQUEST: m_element_requested=1 for exactly this cycle; go COLLECT.
- COLLECT: each m_element_ready sample registers m_element, drives weight_memory_address={filter, tap}, weight_memory_enable=1, tap++. After the VECTOR_LEN-th sample go DRAIN.
- DRAIN: 2 cycles flushing the pipeline; then register result, go DONE.
- DONE: result_valid=1, result held stable until result_ready=1; then go IDLE, or REQUEST if start=1 that same cycle.
- m_element_ready outside COLLECT ignored; start outside IDLE/DONE-handshake ignored.
- Arithmetic: product = 16x16 signed -> 32 bits; accumulator 35 bits signed (32 + log2 VECTOR_LEN), no overflow possible. Result = acc arithmetically shifted right FRAC_BITS (truncation toward -inf), saturated to [0x8000, 0x7FFF].
- clear at any time: state IDLE, accumulator, tap counter, pipeline regs zeroed; in-flight vector discarded.
- Reset values: busy 0, m_element_requested 0, weight_memory_address 0, weight_memory_enable 0, result 0x0000, result_valid 0.

## Timing
- Pipeline per element: edge E0 samples ready (element + address registered); E1 memory returns weight, element delayed one stage; E2 accumulator += element x weight.
- Back-to-back ready pulses (one per cycle) supported with no stalls.
- result_valid rises 3 cycles after the edge sampling the last m_element_ready.
- start -> m_element_requested: 1 cycle.
- Tap counter wraps at VECTOR_LEN; address tap field is the pre-increment value.

## Configuration
- FILTER_MAC_RELU_EN defined: negative accumulator values produce result 0x0000 (ReLU applied before saturation); positive path unchanged.
- Undefined: signed saturated result passed through, negatives preserved.

## Structure
- Shared package nn_pkg: Q-format constants (DATA_WIDTH, FRAC_BITS), VECTOR_LEN, accumulator width, FSM state typedef, saturation limits.
- One sub-module: fixed_point_saturate (acc in, shift + optional ReLU + clamp, 16-bit out), combinational, reused by later layers.

## Test plan
- Elements all 0x0100 (1.0), filter 0 weights all 0x0080 (0.5) -> result 0x0400 (4.0), result_valid 3 cycles after last ready.
- Elements 0x7FFF, weights 0x7FFF -> result 0x7FFF (positive saturation); elements 0x8000, weights 0x7FFF -> 0x8000.
- Elements 0x0100, weights 0xFF00 (-1.0) -> 0xF800 without FILTER_MAC_RELU_EN, 0x0000 with it.
- Hold result_ready low 5 cycles in DONE, pulse start and m_element_ready meanwhile -> result stable, no m_element_requested, no address activity.
- Assert clear after 4 of 8 elements -> all outputs zero next cycle, IDLE; subsequent start with filter 2 gives correct clean dot product.
- Ready pulses with gaps (1,0,1,1,0,...) and filter_select 3 -> addresses 24..31 in order, correct sum.
